// File: rtl/mux_4to1_rr_arb.sv
// Four-channel data mux with a round-robin arbiter in front of it.
// A holder is preempted after HOLD_MAX grant cycles when another requester is waiting.
module mux_4to1_rr_arb #(
    parameter int n        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [n-1:0] q0,
    input  logic [n-1:0] q1,
    input  logic [n-1:0] q2,
    input  logic [n-1:0] q3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic         en,
    output logic [n-1:0] d,
    output logic         valid,
    output logic         dbg_state,
    output logic [3:0]   dbg_cnt,
    output logic [1:0]   dbg_ptr
);

    // Handshake: req[i] is a level held high while requester i wants the mux;
    // gnt[i] is the registered answer, and valid marks d as one cycle of owner data.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] CNT_MAX = 4'(HOLD_MAX - 1);

    state_t       r_state, w_nxt_state;
    logic [3:0]   r_gnt, w_nxt_gnt;
    logic [1:0]   r_sel, w_nxt_sel;
    logic [1:0]   r_ptr, w_nxt_ptr;
    logic [3:0]   r_cnt, w_nxt_cnt;
    logic         r_en;
    logic [n-1:0] r_d;
    logic         r_valid;
    logic [n-1:0] w_q [4];
    logic [3:0]   w_others;
    logic         w_own;
    logic [1:0]   w_win;

    // First asserted bit at base+1, base+2, base+3, base (mod 4).
    function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        f_pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) f_pick = idx;
        end
    endfunction

    assign w_q[0]   = q0;
    assign w_q[1]   = q1;
    assign w_q[2]   = q2;
    assign w_q[3]   = q3;
    assign w_own    = req[r_sel];
    assign w_others = req & ~(4'b0001 << r_sel);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_win       = f_pick(req, r_ptr);
        case (r_state)
            IDLE: begin
                w_nxt_gnt = 4'b0000;
                if (req != 4'b0000) begin
                    w_nxt_state = BUSY;
                    w_nxt_gnt   = 4'b0001 << w_win;
                    w_nxt_sel   = w_win;
                    w_nxt_ptr   = w_win;
                    w_nxt_cnt   = 4'd0;
                end
            end
            BUSY: begin
                // Release takes priority over preemption; both hand off straight to the next owner.
                if (!w_own || (w_others != 4'b0000 && r_cnt == CNT_MAX)) begin
                    if (w_others != 4'b0000) begin
                        w_win     = f_pick(w_others, r_ptr);
                        w_nxt_gnt = 4'b0001 << w_win;
                        w_nxt_sel = w_win;
                        w_nxt_ptr = w_win;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_gnt   = 4'b0000;
                    end
                    w_nxt_cnt = 4'd0;
                end else if (r_cnt != CNT_MAX) begin
                    w_nxt_cnt = r_cnt + 4'd1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd3;
            r_cnt   <= 4'd0;
            r_en    <= 1'b0;
            r_d     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_gnt   <= w_nxt_gnt;
            r_sel   <= w_nxt_sel;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_en    <= |w_nxt_gnt;
            if (r_state == BUSY && w_own) begin
                r_d     <= w_q[r_sel];
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign en        = r_en;
    assign d         = r_d;
    assign valid     = r_valid;
    assign dbg_state = r_state;
    assign dbg_cnt   = r_cnt;
    assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux_4to1_rr_arb.sv
// Directed bench for mux_4to1_rr_arb: reset, rotation, handoff, saturation,
// asynchronous reset and release-versus-preempt cases.
module tb_mux_4to1_rr_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] q0, q1, q2, q3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic [7:0] d;
    logic       valid;
    logic       dbg_state;
    logic [3:0] dbg_cnt;
    logic [1:0] dbg_ptr;

    int tests_run    = 0;
    int tests_failed = 0;

    mux_4to1_rr_arb #(.n(8), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .gnt(gnt), .sel(sel), .en(en), .d(d), .valid(valid),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt), .dbg_ptr(dbg_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    task automatic set_q(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] e);
        q0 = a; q1 = b; q2 = c; q3 = e;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({gnt, sel, en, d, valid, dbg_state, dbg_cnt, dbg_ptr} !== {4'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd3}) begin
            tests_failed++;
            $display("FAIL reset_values gnt=%b sel=%0d en=%b d=%h valid=%b st=%b cnt=%0d ptr=%0d expected all zero, ptr=3",
                     gnt, sel, en, d, valid, dbg_state, dbg_cnt, dbg_ptr);
        end
        req = 4'b0000;
        rst = 1'b1;
        step();
        tests_run++;
        if ({gnt, en, valid, dbg_state, sel, dbg_ptr} !== {4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3}) begin
            tests_failed++;
            $display("FAIL idle_no_req gnt=%b en=%b valid=%b st=%b sel=%0d ptr=%0d expected 0000 0 0 0 0 3",
                     gnt, en, valid, dbg_state, sel, dbg_ptr);
        end
    endtask

    task automatic test_single_request();
        do_reset();
        set_q(8'hA5, 8'h11, 8'h22, 8'h33);
        req = 4'b0001;
        step();
        tests_run++;
        if ({gnt, sel, en, valid} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_edge1 gnt=%b sel=%0d en=%b valid=%b expected 0001 0 1 0", gnt, sel, en, valid);
        end
        step();
        tests_run++;
        if ({valid, d} !== {1'b1, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_edge2 valid=%b d=%h expected 1 a5", valid, d);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] qv [4];
        logic [3:0] exp_gnt;
        int         own;
        int         prev;
        qv[0] = 8'h10; qv[1] = 8'h21; qv[2] = 8'h32; qv[3] = 8'h43;
        do_reset();
        set_q(qv[0], qv[1], qv[2], qv[3]);
        req = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            step();
            own     = (k / 4) % 4;
            exp_gnt = 4'b0001 << own;
            tests_run++;
            if (gnt !== exp_gnt || sel !== 2'(own) || en !== 1'b1) begin
                tests_failed++;
                $display("FAIL rotation_gnt edge=%0d gnt=%b sel=%0d en=%b expected %b %0d 1", k + 1, gnt, sel, en, exp_gnt, own);
            end
            if (k >= 1) begin
                prev = ((k - 1) / 4) % 4;
                tests_run++;
                if (valid !== 1'b1 || d !== qv[prev]) begin
                    tests_failed++;
                    $display("FAIL rotation_data edge=%0d valid=%b d=%h expected 1 %h", k + 1, valid, d, qv[prev]);
                end
            end
        end
    endtask

    task automatic test_release_handoff();
        do_reset();
        set_q(8'h01, 8'h02, 8'h03, 8'hC3);
        req = 4'b0100;
        step();
        req = 4'b1101;
        step();
        req = 4'b1001;
        step();
        tests_run++;
        if ({gnt, sel, valid} !== {4'b1000, 2'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL handoff_edge gnt=%b sel=%0d valid=%b expected 1000 3 0", gnt, sel, valid);
        end
        step();
        tests_run++;
        if ({gnt, valid, d} !== {4'b1000, 1'b1, 8'hC3}) begin
            tests_failed++;
            $display("FAIL handoff_data gnt=%b valid=%b d=%h expected 1000 1 c3", gnt, valid, d);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        do_reset();
        set_q(8'h55, 8'h66, 8'h77, 8'h88);
        req = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            step();
            exp_cnt = (c - 1 > 3) ? 4'd3 : 4'(c - 1);
            tests_run++;
            if (gnt !== 4'b0100 || dbg_cnt !== exp_cnt || valid !== (c >= 2) || (c >= 2 && d !== 8'h77)) begin
                tests_failed++;
                $display("FAIL saturation cycle=%0d gnt=%b cnt=%0d valid=%b d=%h expected 0100 %0d %b 77",
                         c, gnt, dbg_cnt, valid, d, exp_cnt, (c >= 2));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_q(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        req = 4'b0010;
        step();
        step();
        tests_run++;
        if ({gnt, valid, d} !== {4'b0010, 1'b1, 8'hBC}) begin
            tests_failed++;
            $display("FAIL async_precond gnt=%b valid=%b d=%h expected 0010 1 bc", gnt, valid, d);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({gnt, sel, en, d, valid, dbg_state, dbg_cnt, dbg_ptr} !== {4'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd3}) begin
            tests_failed++;
            $display("FAIL async_clear gnt=%b sel=%0d en=%b d=%h valid=%b st=%b cnt=%0d ptr=%0d expected zeros ptr=3",
                     gnt, sel, en, d, valid, dbg_state, dbg_cnt, dbg_ptr);
        end
        req = 4'b1010;
        rst = 1'b1;
        step();
        tests_run++;
        if ({gnt, sel, en} !== {4'b0010, 2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL async_restart gnt=%b sel=%0d en=%b expected 0010 1 1", gnt, sel, en);
        end
    endtask

    task automatic test_release_preempt();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if ({gnt, dbg_cnt} !== {4'b0001, 4'd3}) begin
            tests_failed++;
            $display("FAIL relpre_precond gnt=%b cnt=%0d expected 0001 3", gnt, dbg_cnt);
        end
        req = 4'b0010;
        step();
        tests_run++;
        if ({gnt, sel, dbg_cnt, valid} !== {4'b0010, 2'd1, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL relpre_edge gnt=%b sel=%0d cnt=%0d valid=%b expected 0010 1 0 0", gnt, sel, dbg_cnt, valid);
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        tests_run++;
        if ({gnt, en, valid, dbg_state, sel, dbg_ptr} !== {4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2}) begin
            tests_failed++;
            $display("FAIL idle_return gnt=%b en=%b valid=%b st=%b sel=%0d ptr=%0d expected 0000 0 0 0 2 2",
                     gnt, en, valid, dbg_state, sel, dbg_ptr);
        end
        req = 4'b0101;
        step();
        tests_run++;
        if ({gnt, sel} !== {4'b0001, 2'd0}) begin
            tests_failed++;
            $display("FAIL idle_rearb gnt=%b sel=%0d expected 0001 0", gnt, sel);
        end
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b0000;
        set_q(8'h00, 8'h00, 8'h00, 8'h00);
        #12;
        test_reset();
        test_single_request();
        test_rotation();
        test_release_handoff();
        test_saturation();
        test_async_reset();
        test_release_preempt();
        test_idle_return();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_4to1_rr_arb.md
MUX_4TO1_RR_ARB -- requirements
Module: mux_4to1_rr_arb

Interface
REQ-001 Parameter n, default 8: data width of each input channel and of d.
REQ-002 Parameter HOLD_MAX, default 4: maximum consecutive grant cycles while another requester waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  request lines; req[i] held high for as long as requester i wants the mux.
REQ-006 q0, q1, q2, q3  input  n each  channel data for requesters 0..3.
REQ-007 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-008 sel  output  2  registered binary index of current owner.
REQ-009 en  output  1  registered; equals OR of gnt.
REQ-010 d  output  n  registered data of granted channel.
REQ-011 valid  output  1  registered; high when d holds owner data captured on the previous edge.

Function
REQ-012 FSM states: IDLE (no owner) and BUSY (owner o = sel); pointer ptr[1:0] holds last-granted index; hold counter cnt[3:0].
REQ-013 Arbitration SHALL pick the first asserted req at index ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 IDLE: at an edge with req != 0, enter BUSY, set gnt/sel/en for the winner, set ptr to winner, set cnt to 0; latency req -> gnt is 1 edge.
REQ-015 IDLE with req == 0: stay; gnt=0, en=0, valid=0; sel and ptr hold.
REQ-016 BUSY, req[o] high, no other req: keep owner; cnt increments, saturating at HOLD_MAX-1.
REQ-017 BUSY, req[o] high, other req present, cnt < HOLD_MAX-1: keep owner, cnt increments.
REQ-018 BUSY, req[o] high, other req present, cnt == HOLD_MAX-1: preempt; grant next requester per REQ-013 excluding o, in the same edge, cnt to 0.
REQ-019 BUSY, req[o] low (release): if other req present, hand off in the same edge per REQ-013 excluding o; else enter IDLE with gnt=0.
REQ-020 Release and preempt condition on the same edge SHALL be treated as release.
REQ-021 Grant switches SHALL be glitch-free: gnt never has more than one bit set and never drops to zero between owners on a handoff.
REQ-022 Data path: each edge, if state is BUSY and req[o] high, d <= q[o] and valid <= 1; else d holds and valid <= 0.
REQ-023 valid therefore lags gnt by one cycle and d always originates from the channel granted in the previous cycle.
REQ-024 Starvation bound: a requester holding req high SHALL receive gnt within 3*HOLD_MAX+1 edges.

Reset
REQ-025 rst low SHALL immediately, without clk, force state=IDLE, gnt=0, sel=0, en=0, d=0, valid=0, cnt=0, ptr=3.
REQ-026 Reset asserted mid-BUSY SHALL abandon the owner; after release, arbitration restarts with requester 0 highest priority.
REQ-027 First edge after rst goes high SHALL behave as REQ-014/015 with no extra latency.

Verification
REQ-028 Reset then req=0001, q0=8'hA5 held -> edge 1: gnt=0001, sel=0, en=1; edge 2: valid=1, d=8'hA5.
REQ-029 From reset, req=1111 held, HOLD_MAX=4 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001; never two bits set.
REQ-030 Owner 2 drops req while req=1001 pending -> next edge gnt=1000 (not 0001), valid=0 that edge then valid=1 with d=q3.
REQ-031 Single requester req=0100 held 20 cycles -> gnt stays 0100, cnt saturates at 3, valid continuous from cycle 2.
REQ-032 rst pulsed low between edges while gnt=0010, valid=1 -> all outputs 0 before next edge; after release with req=1010, gnt=0010 (ptr=3 reset priority).
REQ-033 Owner release and hold expiry on same edge with req=0011, owner 0 -> gnt=0010 next edge, identical to pure release.
